// File: rtl/spi_bus_switch_pkg.sv
// Shared types and constants for the SPI pad arbiter: FSM encoding, pad idle
// levels and width helpers for counters and owner indices.
package spi_bus_switch_pkg;

  typedef enum logic [1:0] {
    ST_OWN       = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_GUARD     = 2'd2
  } state_t;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;

  // Bits needed to hold the value max_val itself (saturation point).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_bus_switch_cnt.sv
// Saturating up-counter with synchronous clear; tc flags the enabled cycle
// that carries the count onto MAX.
module spi_bus_switch_cnt
  import spi_bus_switch_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [W-1:0] MAX_V  = W'(MAX);
  localparam logic [W-1:0] LAST_V = W'(MAX - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

  assign tc = en && !clr && (count == LAST_V);

endmodule

// File: rtl/spi_bus_switch.sv
// N-master SPI pad arbiter: hands the SD-card pads to a new master only once
// the current owner is idle (or timed out), with a forced-deselect guard gap.
module spi_bus_switch
  import spi_bus_switch_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int SEL_W          = $clog2(N_MASTERS),
  parameter int RESET_OWNER    = 0,
  parameter int IDLE_CYCLES    = 4,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit CPOL           = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     sel_req,
  input  logic                 sel_valid,
  output logic                 busy_o,
  output logic                 switch_done_o,
  output logic                 sel_err_o,
  output logic                 timeout_o,
  output logic [SEL_W-1:0]     owner_o,
  input  logic [N_MASTERS-1:0] cs_i,
  input  logic [N_MASTERS-1:0] sclk_i,
  input  logic [N_MASTERS-1:0] mosi_i,
  output logic [N_MASTERS-1:0] miso_o,
  output logic                 cs_o,
  output logic                 sclk_o,
  output logic                 mosi_o,
  input  logic                 miso_i
);

  localparam logic [SEL_W:0] N_V    = (SEL_W + 1)'(N_MASTERS);
  localparam int             TO_MAX = (TIMEOUT_CYCLES == 0) ? 1 : TIMEOUT_CYCLES;
  localparam bit             TO_EN  = (TIMEOUT_CYCLES != 0);

  state_t           state, state_next;
  logic [SEL_W-1:0] owner_q, pending_q;
  logic             own_cs, own_sclk, own_mosi;
  logic             req_take, req_bad, req_same, req_switch;
  logic             idle_tc, guard_tc, to_tc, to_hit, guard_last;
  logic             pad_cs_d, pad_sclk_d, pad_mosi_d;

  assign own_cs   = cs_i[owner_q];
  assign own_sclk = sclk_i[owner_q];
  assign own_mosi = mosi_i[owner_q];

  // Handshake: sel_valid is taken on any cycle busy_o is low (state OWN);
  // while busy_o is high the strobe is dropped, there is no queueing.
  assign req_take   = sel_valid && (state == ST_OWN);
  assign req_bad    = req_take && ({1'b0, sel_req} >= N_V);
  assign req_same   = req_take && !req_bad && (sel_req == owner_q);
  assign req_switch = req_take && !req_bad && !req_same;

  spi_bus_switch_cnt #(.MAX(IDLE_CYCLES)) u_idle_cnt (
    .clk (clk),
    .rst (rst),
    .clr ((state != ST_WAIT_IDLE) || !own_cs),
    .en  (1'b1),
    .tc  (idle_tc)
  );

  spi_bus_switch_cnt #(.MAX(GUARD_CYCLES)) u_guard_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_GUARD),
    .en  (1'b1),
    .tc  (guard_tc)
  );

  spi_bus_switch_cnt #(.MAX(TO_MAX)) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_WAIT_IDLE),
    .en  (TO_EN),
    .tc  (to_tc)
  );

  assign to_hit     = TO_EN && to_tc;
  assign guard_last = (state == ST_GUARD) && guard_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OWN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OWN:       if (req_switch) state_next = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (idle_tc || to_hit) state_next = ST_GUARD;
      ST_GUARD:     if (guard_tc) state_next = ST_OWN;
      default:      state_next = ST_OWN;
    endcase
  end

  // The old owner keeps the pads through WAIT_IDLE; only GUARD forces idle.
  always_comb begin
    busy_o     = (state != ST_OWN);
    miso_o     = '1;
    pad_cs_d   = CS_IDLE;
    pad_sclk_d = CPOL;
    pad_mosi_d = MOSI_IDLE;
    if (state == ST_OWN) begin
      miso_o[owner_q] = miso_i;
    end
    if (state != ST_GUARD) begin
      pad_cs_d   = own_cs;
      pad_sclk_d = own_sclk;
      pad_mosi_d = own_mosi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q       <= SEL_W'(RESET_OWNER);
      pending_q     <= SEL_W'(RESET_OWNER);
      cs_o          <= CS_IDLE;
      sclk_o        <= CPOL;
      mosi_o        <= MOSI_IDLE;
      switch_done_o <= 1'b0;
      sel_err_o     <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      cs_o          <= pad_cs_d;
      sclk_o        <= pad_sclk_d;
      mosi_o        <= pad_mosi_d;
      sel_err_o     <= req_bad;
      switch_done_o <= req_same || guard_last;
      if (req_switch) begin
        pending_q <= sel_req;
        timeout_o <= 1'b0;
      end else if ((state == ST_WAIT_IDLE) && to_hit && !idle_tc) begin
        timeout_o <= 1'b1;
      end
      if (guard_last) begin
        owner_q <= pending_q;
      end
    end
  end

  assign owner_o = owner_q;

endmodule

// File: tb/tb_spi_bus_switch.sv
// Directed bench for spi_bus_switch with three masters, 4 idle cycles,
// a 16-cycle guard gap and a 64-cycle timeout.
module tb_spi_bus_switch;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   sel_req = 2'd0;
  logic         sel_valid = 1'b0;
  logic         busy_o, switch_done_o, sel_err_o, timeout_o;
  logic [1:0]   owner_o;
  logic [N-1:0] cs_i = '1;
  logic [N-1:0] sclk_i = '0;
  logic [N-1:0] mosi_i = '1;
  logic [N-1:0] miso_o;
  logic         cs_o, sclk_o, mosi_o;
  logic         miso_i = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  spi_bus_switch #(
    .N_MASTERS(N), .SEL_W(2), .RESET_OWNER(0), .IDLE_CYCLES(4),
    .GUARD_CYCLES(16), .TIMEOUT_CYCLES(64), .CPOL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .sel_valid(sel_valid),
    .busy_o(busy_o), .switch_done_o(switch_done_o), .sel_err_o(sel_err_o),
    .timeout_o(timeout_o), .owner_o(owner_o), .cs_i(cs_i), .sclk_i(sclk_i),
    .mosi_i(mosi_i), .miso_o(miso_o), .cs_o(cs_o), .sclk_o(sclk_o),
    .mosi_o(mosi_o), .miso_i(miso_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL reset_owner: got %0d want 0", owner_o); end
    n_cmp++; if (cs_o !== 1'b1) begin n_bad++; $display("FAIL reset_cs: got %b want 1", cs_o); end
    n_cmp++; if (sclk_o !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b want 0", sclk_o); end
    n_cmp++; if (mosi_o !== 1'b1) begin n_bad++; $display("FAIL reset_mosi: got %b want 1", mosi_o); end
    n_cmp++; if ({busy_o, switch_done_o, sel_err_o, timeout_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy_o, switch_done_o, sel_err_o, timeout_o}); end
    n_cmp++; if (miso_o !== 3'b110) begin n_bad++; $display("FAIL reset_miso: got %b want 110", miso_o); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic prev_s, s, m;
    prev_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = (i % 2 == 0);
      m = (i % 3 == 0);
      cs_i   = 3'b110;
      sclk_i = {~s, ~s, s};
      mosi_i = {~m, ~m, m};
      miso_i = i[0];
      #1;
      n_cmp++; if (sclk_o !== prev_s) begin n_bad++; $display("FAIL pass_latency[%0d]: got %b want %b", i, sclk_o, prev_s); end
      n_cmp++; if (miso_o !== {2'b11, m ? i[0] : i[0]}) begin n_bad++; $display("FAIL pass_miso[%0d]: got %b want %b", i, miso_o, {2'b11, i[0]}); end
      tick();
      n_cmp++; if ({cs_o, sclk_o, mosi_o} !== {1'b0, s, m}) begin
        n_bad++; $display("FAIL pass_pads[%0d]: got %b want %b", i, {cs_o, sclk_o, mosi_o}, {1'b0, s, m}); end
      prev_s = s;
    end
    cs_i = '1; sclk_i = '0; mosi_i = '1; miso_i = 1'b0;
    tick();
  endtask

  task automatic test_idle_handover();
    cs_i[2] = 1'b0; sclk_i[2] = 1'b1; mosi_i[2] = 1'b0;
    sel_req = 2'd2; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL ho_busy_rise: got %b want 1", busy_o); end
    n_cmp++; if (miso_o !== 3'b111) begin n_bad++; $display("FAIL ho_miso_wait: got %b want 111", miso_o); end
    repeat (4) tick();
    n_cmp++; if ({busy_o, owner_o} !== {1'b1, 2'd0}) begin n_bad++; $display("FAIL ho_wait_end: got %b want 100", {busy_o, owner_o}); end
    cs_i[0] = 1'b0; sclk_i[0] = 1'b1; mosi_i[0] = 1'b0;
    for (int g = 1; g <= 16; g++) begin
      if (g == 3) begin sel_req = 2'd1; sel_valid = 1'b1; end
      else sel_valid = 1'b0;
      tick();
      n_cmp++; if ({cs_o, sclk_o, mosi_o, sel_err_o} !== 4'b1010) begin
        n_bad++; $display("FAIL ho_guard_pads[%0d]: got %b want 1010", g, {cs_o, sclk_o, mosi_o, sel_err_o}); end
      if (g < 16) begin
        n_cmp++; if ({switch_done_o, busy_o, owner_o} !== 4'b0100) begin
          n_bad++; $display("FAIL ho_guard_state[%0d]: got %b want 0100", g, {switch_done_o, busy_o, owner_o}); end
      end else begin
        n_cmp++; if ({switch_done_o, busy_o, owner_o, miso_o} !== 7'b1010011) begin
          n_bad++; $display("FAIL ho_done: got %b want 1010011", {switch_done_o, busy_o, owner_o, miso_o}); end
      end
    end
    tick();
    n_cmp++; if ({cs_o, sclk_o, mosi_o, switch_done_o} !== 4'b0100) begin
      n_bad++; $display("FAIL ho_new_owner_pads: got %b want 0100", {cs_o, sclk_o, mosi_o, switch_done_o}); end
    cs_i = '1; sclk_i = '0; mosi_i = '1;
    tick();
  endtask

  task automatic test_deferred();
    logic exp_cs, exp_s;
    int found;
    cs_i[2] = 1'b0;
    tick();
    sel_req = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      exp_cs = (c == 20 || c == 21);
      exp_s  = c[0];
      cs_i[2] = exp_cs; sclk_i[2] = exp_s;
      tick();
      n_cmp++; if ({cs_o, sclk_o, busy_o} !== {exp_cs, exp_s, 1'b1}) begin
        n_bad++; $display("FAIL def_follow[%0d]: got %b want %b", c, {cs_o, sclk_o, busy_o}, {exp_cs, exp_s, 1'b1}); end
    end
    cs_i[2] = 1'b1; sclk_i[2] = 1'b1; mosi_i[2] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if ({cs_o, sclk_o, mosi_o, busy_o} !== 4'b1101) begin
        n_bad++; $display("FAIL def_idle_wait[%0d]: got %b want 1101", k, {cs_o, sclk_o, mosi_o, busy_o}); end
    end
    tick();
    n_cmp++; if ({cs_o, sclk_o, mosi_o} !== 3'b101) begin
      n_bad++; $display("FAIL def_guard_entry: got %b want 101", {cs_o, sclk_o, mosi_o}); end
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (switch_done_o === 1'b1) begin found = k; break; end
    end
    n_cmp++; if (found != 15) begin n_bad++; $display("FAIL def_done_time: got %0d want 15", found); end
    n_cmp++; if (owner_o !== 2'd0) begin n_bad++; $display("FAIL def_owner: got %0d want 0", owner_o); end
    cs_i = '1; sclk_i = '0; mosi_i = '1;
    tick();
  endtask

  task automatic test_timeout();
    int found;
    cs_i[0] = 1'b0; sclk_i[0] = 1'b1; mosi_i[0] = 1'b0;
    sel_req = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_cmp++; if ({timeout_o, busy_o} !== 2'b01) begin n_bad++; $display("FAIL to_start: got %b want 01", {timeout_o, busy_o}); end
    repeat (63) tick();
    n_cmp++; if ({cs_o, timeout_o, busy_o} !== 3'b001) begin n_bad++; $display("FAIL to_cycle63: got %b want 001", {cs_o, timeout_o, busy_o}); end
    tick();
    n_cmp++; if ({cs_o, sclk_o, timeout_o} !== 3'b011) begin n_bad++; $display("FAIL to_cycle64: got %b want 011", {cs_o, sclk_o, timeout_o}); end
    tick();
    n_cmp++; if ({cs_o, sclk_o, timeout_o} !== 3'b101) begin n_bad++; $display("FAIL to_guard: got %b want 101", {cs_o, sclk_o, timeout_o}); end
    found = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (switch_done_o === 1'b1) begin found = k; break; end
    end
    n_cmp++; if (found != 15) begin n_bad++; $display("FAIL to_done_time: got %0d want 15", found); end
    n_cmp++; if ({owner_o, timeout_o} !== 3'b011) begin n_bad++; $display("FAIL to_owner_sticky: got %b want 011", {owner_o, timeout_o}); end
    cs_i = '1; sclk_i = '0; mosi_i = '1;
    repeat (3) tick();
    n_cmp++; if (timeout_o !== 1'b1) begin n_bad++; $display("FAIL to_hold: got %b want 1", timeout_o); end
    sel_req = 2'd0; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_cmp++; if ({timeout_o, busy_o} !== 2'b01) begin n_bad++; $display("FAIL to_clear: got %b want 01", {timeout_o, busy_o}); end
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (switch_done_o === 1'b1) begin found = k; break; end
    end
    n_cmp++; if (found != 20) begin n_bad++; $display("FAIL to_back_time: got %0d want 20", found); end
    n_cmp++; if ({owner_o, timeout_o} !== 3'b000) begin n_bad++; $display("FAIL to_back_owner: got %b want 000", {owner_o, timeout_o}); end
    tick();
  endtask

  task automatic test_invalid_same();
    sel_req = 2'd3; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    n_cmp++; if ({sel_err_o, busy_o, switch_done_o, owner_o} !== 5'b10000) begin
      n_bad++; $display("FAIL inv_pulse: got %b want 10000", {sel_err_o, busy_o, switch_done_o, owner_o}); end
    tick();
    n_cmp++; if ({sel_err_o, owner_o} !== 3'b000) begin n_bad++; $display("FAIL inv_clear: got %b want 000", {sel_err_o, owner_o}); end
    cs_i[0] = 1'b0; sclk_i[0] = 1'b1; mosi_i[0] = 1'b0;
    tick();
    sel_req = 2'd0; sel_valid = 1'b1; sclk_i[0] = 1'b0;
    tick();
    sel_valid = 1'b0;
    n_cmp++; if ({switch_done_o, busy_o, cs_o, sclk_o, mosi_o} !== 5'b10000) begin
      n_bad++; $display("FAIL same_pulse: got %b want 10000", {switch_done_o, busy_o, cs_o, sclk_o, mosi_o}); end
    sclk_i[0] = 1'b1;
    tick();
    n_cmp++; if ({switch_done_o, cs_o, sclk_o, owner_o} !== 5'b00100) begin
      n_bad++; $display("FAIL same_continue: got %b want 00100", {switch_done_o, cs_o, sclk_o, owner_o}); end
    cs_i = '1; sclk_i = '0; mosi_i = '1;
    tick();
  endtask

  task automatic test_reset_mid_guard();
    int seen;
    sel_req = 2'd1; sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
    repeat (8) tick();
    n_cmp++; if (busy_o !== 1'b1) begin n_bad++; $display("FAIL rmg_in_guard: got %b want 1", busy_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({owner_o, busy_o, cs_o, sclk_o, mosi_o, switch_done_o} !== 7'b0001010) begin
      n_bad++; $display("FAIL rmg_async: got %b want 0001010", {owner_o, busy_o, cs_o, sclk_o, mosi_o, switch_done_o}); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (switch_done_o === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rmg_no_done: got %0d want 0", seen); end
    n_cmp++; if ({owner_o, busy_o} !== 3'b000) begin n_bad++; $display("FAIL rmg_owner: got %b want 000", {owner_o, busy_o}); end
    cs_i[0] = 1'b0;
    tick();
    n_cmp++; if (cs_o !== 1'b0) begin n_bad++; $display("FAIL rmg_pass: got %b want 0", cs_o); end
    cs_i = '1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_idle_handover();
    test_deferred();
    test_timeout();
    test_invalid_same();
    test_reset_mid_guard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
